// File: rtl/cache_tb_pkg.sv
// cache_tb_pkg: shared state encoding and replay mode constants for the trace player
package cache_tb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, FINISH, DONE_PULSE} state_t;
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_STRIDE = 2'd2;
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return m == 2'd3 ? MODE_SINGLE : m;
    endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: address trace storage with one write port and one registered read port
module trace_ram #(
    parameter int ADDR_W = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [ADDR_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [ADDR_W-1:0]     rdata
);
    logic [ADDR_W-1:0] mem [2**DEPTH_LOG2];
    // write the addressed entry and register the read data
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cache_trace_player.sv
// cache_trace_player: replays a stored or generated address trace into the cache and counts hits/misses
module cache_trace_player
    import cache_tb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      num_accesses,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_idx,
    input  logic [ADDR_W-1:0]     load_data,
    input  logic [DEPTH_LOG2:0]   trace_len,
    output logic                  req_valid,
    output logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic                  resp_hit,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      access_count,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);
    state_t state, state_d;
    logic armed, stop_pend, accept, respond, stop_now, last;
    logic [DEPTH_LOG2-1:0] idx, idx_d;
    logic [DEPTH_LOG2:0] len_q;
    logic [ADDR_W-1:0] gen_addr, rd_data;
    logic [CNT_W-1:0] num_q, acc_inc, limit;
    logic [1:0] mode_q;

    assign accept = state == ISSUE && armed && req_ready;
    assign respond = state == WAIT_RESP && resp_valid;
    assign stop_now = stop || stop_pend;
    assign acc_inc = &access_count ? access_count : access_count + CNT_W'(1);
    assign limit = num_q == '0 ? CNT_W'(len_q) : num_q;
    assign last = stop_now || (mode_q == MODE_LOOP ? 1'b0 :
                               mode_q == MODE_STRIDE ? num_q != '0 && acc_inc == num_q :
                               acc_inc == limit);
    // RAM is addressed with the upcoming index so its data is ready one cycle into ISSUE
    assign idx_d = state == IDLE && start ? '0 :
                   !respond ? idx :
                   {1'b0, idx} == len_q - (DEPTH_LOG2+1)'(1) ? '0 : idx + DEPTH_LOG2'(1);

    trace_ram #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk(clock),
        .we(load_en && state == IDLE),
        .waddr(load_idx),
        .wdata(load_data),
        .raddr(idx_d),
        .rdata(rd_data)
    );

    // run sequencing and state-derived outputs
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = start ? ISSUE : IDLE;
            ISSUE:     state_d = accept ? WAIT_RESP : stop_now ? FINISH : ISSUE;
            WAIT_RESP: state_d = !resp_valid ? WAIT_RESP : last ? FINISH : ISSUE;
            FINISH:    state_d = DONE_PULSE;
            default:   state_d = IDLE;
        endcase
        req_valid = state == ISSUE && armed;
        busy = state inside {ISSUE, WAIT_RESP, FINISH};
        done = state == DONE_PULSE;
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    // run parameters, address generation and saturating statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
            stop_pend <= 1'b0;
            idx <= '0;
            gen_addr <= '0;
            mode_q <= MODE_SINGLE;
            num_q <= '0;
            len_q <= '0;
            req_addr <= '0;
            access_count <= '0;
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            idx <= idx_d;
            armed <= state == ISSUE && state_d == ISSUE;
            stop_pend <= state_d == WAIT_RESP && stop_now;
            if (state == ISSUE && !armed) req_addr <= mode_q == MODE_STRIDE ? gen_addr : rd_data;
            if (state == IDLE && start) begin
                gen_addr <= base_addr;
                mode_q <= norm_mode(mode);
                num_q <= num_accesses;
                len_q <= trace_len;
                access_count <= '0;
                hit_count <= '0;
                miss_count <= '0;
            end
            if (respond) begin
                gen_addr <= gen_addr + stride;
                access_count <= acc_inc;
                if (resp_hit && !(&hit_count)) hit_count <= hit_count + CNT_W'(1);
                if (!resp_hit && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/cache_trace_player.md
Name: cache_trace_player

Overview:
- Synthesizable address-trace replay engine that drives the compressed-cache top level with a stream of 32-bit (parametrised) addresses.
- Successor to the file-driven stimulus: addresses come from an internal loadable trace RAM or from a built-in stride generator.
- Presented to the cache over a valid/ready request handshake, one outstanding access at a time.
- Collects per-access hit/miss responses into saturating statistics counters for hit-rate measurement of the YACC/LRU cache.

Parameters:
- ADDR_W, 32, width of cache address and trace entries
- DEPTH_LOG2, 10, trace RAM holds 2**DEPTH_LOG2 entries
- CNT_W, 32, width of access/hit/miss counters and num_accesses

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when in IDLE, ignored otherwise
- stop  in  1  one-cycle pulse; ends the run after the current access completes
- mode  in  2  0=single pass over trace, 1=loop trace until stop, 2=stride generator, 3=reserved (treated as 0)
- num_accesses  in  CNT_W  accesses to issue in modes 0/2; 0 means "all trace entries" (mode 0) or "until stop" (mode 2)
- base_addr  in  ADDR_W  stride-mode start address
- stride  in  ADDR_W  stride-mode increment
- load_en  in  1  trace RAM write strobe, honoured only in IDLE
- load_idx  in  DEPTH_LOG2  trace RAM write index
- load_data  in  ADDR_W  trace RAM write data
- trace_len  in  DEPTH_LOG2+1  number of valid trace entries (1..2**DEPTH_LOG2)
- req_valid  out  1  request to cache
- req_addr  out  ADDR_W  request address
- req_ready  in  1  cache accepts request
- resp_valid  in  1  cache reports result of accepted request
- resp_hit  in  1  1=hit, 0=miss, qualified by resp_valid
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- access_count  out  CNT_W  completed accesses
- hit_count  out  CNT_W  hits
- miss_count  out  CNT_W  misses

Behaviour:
- Reset (async): state=IDLE; req_valid=0, req_addr=0, busy=0, done=0, all counters=0, index=0. Trace RAM contents are not reset.
- States: IDLE -> (start) ISSUE -> (req_valid&req_ready) WAIT_RESP -> (resp_valid) ISSUE or FINISH -> DONE_PULSE -> IDLE.
- start in IDLE:
  - clears counters, index=0, gen_addr=base_addr, latches mode/num_accesses/trace_len.
  - busy=1 from the next cycle.
- ISSUE: req_valid=1 and req_addr registered.
  - req_addr = trace RAM[index] (1-cycle RAM read, prefetched at state entry) or gen_addr.
  - req_addr holds stable while req_valid=1 && !req_ready.
- WAIT_RESP: req_valid=0. On resp_valid:
  - access_count+1; hit_count+1 if resp_hit, else miss_count+1.
  - All counters saturate at all-ones.
- Advance after each response:
  - index wraps to 0 at trace_len-1.
  - gen_addr += stride, modulo 2**ADDR_W.
- Termination (checked on resp_valid):
  - mode 0: access_count reaches num_accesses, or trace_len when num_accesses=0.
  - mode 1: stop only.
  - mode 2: num_accesses, or stop when num_accesses=0.
- stop:
  - Latched as a pending flag, acted on at the next response; an accepted request is never abandoned.
  - stop in ISSUE before acceptance: deassert req_valid next cycle, go to FINISH with no further access.
- Simultaneous start and stop in IDLE: start wins, and the stop is ignored.
- Response timing:
  - resp_valid outside WAIT_RESP is ignored and not counted.
  - Same-cycle acceptance and response is not legal; the cache responds at least 1 cycle after acceptance.
- Latency: start to first req_valid = 2 cycles (RAM prefetch).
- DONE_PULSE: done=1 for exactly one cycle, busy=0 in the same cycle; counters hold until the next start.
- load_en while busy is ignored.
- Reset mid-run aborts immediately with no done pulse.

Decomposition:
- Shared package cache_tb_pkg:
  - state enum (IDLE, ISSUE, WAIT_RESP, FINISH, DONE_PULSE)
  - mode constants MODE_SINGLE/MODE_LOOP/MODE_STRIDE
- One sub-module trace_ram:
  - 1 write port, 1 registered read port
  - parametrised by ADDR_W, DEPTH_LOG2

Test Plan:
- Load 4 entries {0x100,0x104,0x100,0x200}, trace_len=4, mode 0, num_accesses=0, cache always ready, responds hit/miss/hit/miss -> req_addr sequence matches, access=4, hit=2, miss=2, single done pulse.
- Mode 2, base=0xFFFFFFF8, stride=4, num_accesses=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap), done after 4th response.
- Mode 1, trace_len=3, stop pulsed during 7th WAIT_RESP -> 7 accesses counted, addresses cycle idx 0,1,2,0,1,2,0, done pulse.
- req_ready held low 5 cycles on 2nd request -> req_valid/req_addr stable throughout, no duplicate count.
- Async reset asserted mid-WAIT_RESP -> all outputs 0 immediately, no done; new start runs cleanly from index 0.
- load_en pulsed while busy with load_data=0xDEAD at index 0 -> RAM unchanged; second run replays original entry.
